// File: rtl/sti_rx_deserializer_if.sv
// rtl/sti_rx_deserializer_if.sv - serial input and word/byte output bundle of the STI receive deserializer
interface sti_rx_deserializer_if;
  logic        so_valid;
  logic        so_data;
  logic        rx_msb;
  logic [31:0] rx_word;
  logic [5:0]  rx_len;
  logic        rx_done;
  logic        byte_wr;
  logic [7:0]  byte_addr;
  logic [7:0]  byte_data;
  logic        byte_full;
  logic        rx_err;

  modport master (
    output so_valid, so_data, rx_msb,
    input  rx_word, rx_len, rx_done, byte_wr, byte_addr, byte_data, byte_full, rx_err
  );

  modport slave (
    input  so_valid, so_data, rx_msb,
    output rx_word, rx_len, rx_done, byte_wr, byte_addr, byte_data, byte_full, rx_err
  );
endinterface

// File: rtl/sti_rx_deserializer.sv
// rtl/sti_rx_deserializer.sv - rebuilds STI serial bursts into words and a byte-wide pixel buffer write port
// Optional burst-format checking on rx_err is built only when STI_RX_ERR_EN is defined.
module sti_rx_deserializer (
  input  logic                   clk,
  input  logic                   reset,
  sti_rx_deserializer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [5:0]  cnt_q;
  logic [31:0] sh_q;
  logic        msb_q;
  logic [2:0]  bc_q;
  logic [7:0]  pb_q;

  logic [31:0] word_q;
  logic [5:0]  len_q;
  logic        done_q;
  logic        wr_q;
  logic [7:0]  addr_q;
  logic [7:0]  data_q;
  logic        full_q;

  logic        start;
  logic        take;
  logic        burst_end;
  logic        accept;
  logic        cur_msb;
  logic [2:0]  cur_bc;
  logic [31:0] sh_base;
  logic [31:0] sh_n;
  logic [7:0]  pb_n;
  logic        byte_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    take      = 1'b0;
    burst_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.so_valid) begin
          start   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.so_valid) begin
          take = 1'b1;
        end else begin
          burst_end = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.so_valid) begin
          start   = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A burst start sees a cleared shift register and byte counter, so the
  // first bit of a back-to-back burst lands exactly like one after idle.
  always_comb begin
    cur_msb = start ? bus.rx_msb : msb_q;
    cur_bc  = start ? 3'd0 : bc_q;
    sh_base = start ? 32'd0 : sh_q;
    accept  = start || (take && (cnt_q != 6'd32));

    sh_n = sh_base;
    if (cur_msb) begin
      sh_n = {sh_base[30:0], bus.so_data};
    end else begin
      sh_n[start ? 5'd0 : cnt_q[4:0]] = bus.so_data;
    end

    pb_n = start ? 8'd0 : pb_q;
    pb_n[cur_msb ? (3'd7 - cur_bc) : cur_bc] = bus.so_data;

    byte_done = accept && (cur_bc == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 6'd0;
      sh_q   <= 32'd0;
      msb_q  <= 1'b0;
      bc_q   <= 3'd0;
      pb_q   <= 8'd0;
      word_q <= 32'd0;
      len_q  <= 6'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= burst_end;
      if (burst_end) begin
        word_q <= sh_q;
        len_q  <= cnt_q;
      end
      if (accept) begin
        sh_q  <= sh_n;
        pb_q  <= pb_n;
        bc_q  <= cur_bc + 3'd1;
        cnt_q <= start ? 6'd1 : (cnt_q + 6'd1);
        if (start) begin
          msb_q <= bus.rx_msb;
        end
      end
    end
  end

  // addr_q is shown during the write strobe and advances afterwards, so once
  // address 255 has been written the port parks at 0 with writes suppressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= 1'b0;
      addr_q <= 8'd0;
      data_q <= 8'd0;
      full_q <= 1'b0;
    end else begin
      wr_q <= byte_done && !full_q;
      if (byte_done && !full_q) begin
        data_q <= pb_n;
      end
      if (wr_q) begin
        addr_q <= addr_q + 8'd1;
        if (addr_q == 8'd255) begin
          full_q <= 1'b1;
        end
      end
    end
  end

`ifdef STI_RX_ERR_EN
  logic over_q;
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      over_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (start) begin
        over_q <= 1'b0;
      end else if (take && (cnt_q == 6'd32)) begin
        over_q <= 1'b1;
      end
      err_q <= burst_end && (over_q || (cnt_q[2:0] != 3'd0));
    end
  end

  assign bus.rx_err = err_q;
`else
  assign bus.rx_err = 1'b0;
`endif

  assign bus.rx_word   = word_q;
  assign bus.rx_len    = len_q;
  assign bus.rx_done   = done_q;
  assign bus.byte_wr   = wr_q;
  assign bus.byte_addr = addr_q;
  assign bus.byte_data = data_q;
  assign bus.byte_full = full_q;

endmodule

// File: tb/tb_sti_rx_deserializer.sv
// tb/tb_sti_rx_deserializer.sv - randomized scoreboard bench for sti_rx_deserializer
module tb_sti_rx_deserializer;

  typedef struct {
    logic [31:0] word;
    logic [5:0]  len;
    logic        err;
  } word_exp_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } byte_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  word_exp_t wq[$];
  byte_exp_t bq[$];
  int        m_addr = 0;
  bit        m_full = 1'b0;

  sti_rx_deserializer_if bus ();

  sti_rx_deserializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the first 32 transmitted bits form the word; every complete
  // group of 8 among them becomes one buffer write until the buffer is full.
  task automatic expect_burst(input logic [39:0] b, input int n, input bit msb);
    int        m;
    word_exp_t we;
    byte_exp_t be;
    longint    w;
    int        by;
    m = (n > 32) ? 32 : n;
    w = 0;
    for (int i = 0; i < m; i++) begin
      if (msb) w = w * 2 + b[i];
      else     w = w + (longint'(b[i]) << i);
    end
    for (int g = 0; g < m / 8; g++) begin
      by = 0;
      for (int k = 0; k < 8; k++) begin
        if (msb) by = by + (int'(b[8*g+k]) << (7 - k));
        else     by = by + (int'(b[8*g+k]) << k);
      end
      if (!m_full) begin
        be.addr = 8'(m_addr);
        be.data = 8'(by);
        bq.push_back(be);
        if (m_addr == 255) begin
          m_full = 1'b1;
          m_addr = 0;
        end else begin
          m_addr++;
        end
      end
    end
    we.word = 32'(w);
    we.len  = 6'(m);
`ifdef STI_RX_ERR_EN
    we.err  = (n > 32) || (n % 8 != 0);
`else
    we.err  = 1'b0;
`endif
    wq.push_back(we);
  endtask

  task automatic drive_bits(input logic [39:0] b, input int n, input bit msb);
    for (int i = 0; i < n; i++) begin
      bus.so_valid = 1'b1;
      bus.so_data  = b[i];
      bus.rx_msb   = (i == 0) ? msb : 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus.so_valid = 1'b0;
      bus.so_data  = 1'($urandom);
      bus.rx_msb   = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_burst(input logic [39:0] b, input int n, input bit msb, input int gap);
    expect_burst(b, n, msb);
    drive_bits(b, n, msb);
    idle(gap);
  endtask

  function automatic logic [39:0] to_bits(input logic [31:0] v, input int n, input bit msb);
    logic [39:0] b;
    b = '0;
    for (int i = 0; i < n; i++) b[i] = msb ? v[n-1-i] : v[i];
    return b;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_word"},   bus.rx_word,   0);
    check({tag, "_rx_len"},    bus.rx_len,    0);
    check({tag, "_rx_done"},   bus.rx_done,   0);
    check({tag, "_byte_wr"},   bus.byte_wr,   0);
    check({tag, "_byte_addr"}, bus.byte_addr, 0);
    check({tag, "_byte_data"}, bus.byte_data, 0);
    check({tag, "_byte_full"}, bus.byte_full, 0);
    check({tag, "_rx_err"},    bus.rx_err,    0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_done) begin
        check("rx_done_pending", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          word_exp_t we;
          we = wq.pop_front();
          check("rx_word", bus.rx_word, we.word);
          check("rx_len",  bus.rx_len,  we.len);
          check("rx_err",  bus.rx_err,  we.err);
        end
      end else if (bus.rx_err) begin
        check("rx_err_without_done", bus.rx_done, 1);
      end
      if (bus.byte_wr) begin
        check("byte_wr_pending", bq.size() != 0, 1);
        if (bq.size() != 0) begin
          byte_exp_t be;
          be = bq.pop_front();
          check("byte_addr", bus.byte_addr, be.addr);
          check("byte_data", bus.byte_data, be.data);
        end
      end
    end
  end

  initial begin
    logic [39:0] b;
    int          n;
    bus.so_valid = 1'b0;
    bus.so_data  = 1'b0;
    bus.rx_msb   = 1'b0;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    idle(2);

    send_burst(to_bits(32'hA5, 8, 1'b1), 8, 1'b1, 1);
    send_burst(to_bits(32'h1234, 16, 1'b0), 16, 1'b0, 1);
    send_burst(to_bits(32'h5A, 8, 1'b1), 8, 1'b1, 1);
    send_burst(to_bits(32'hC3, 8, 1'b0), 8, 1'b0, 3);
    send_burst(to_bits(32'hABC, 12, 1'b1), 12, 1'b1, 2);
    send_burst(to_bits(32'hDEADBEEF, 32, 1'b1), 32, 1'b1, 1);

    for (int k = 0; k < 60; k++) begin
      n = $urandom_range(1, 40);
      b = {8'($urandom), 32'($urandom)};
      send_burst(b, n, 1'($urandom), $urandom_range(1, 3));
    end
    idle(4);
    check("queues_drained_random", wq.size() + bq.size(), 0);
    check("byte_full_random", bus.byte_full, m_full);

    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    m_addr = 0;
    m_full = 1'b0;
    for (int i = 0; i < 256; i++) begin
      send_burst(to_bits(32'(i), 8, 1'b1), 8, 1'b1, 1);
    end
    idle(3);
    check("byte_full_set", bus.byte_full, 1);
    check("byte_addr_parked", bus.byte_addr, 0);
    send_burst(to_bits(32'h77, 8, 1'b0), 8, 1'b0, 3);
    check("byte_full_hold", bus.byte_full, 1);
    check("queues_drained_full", wq.size() + bq.size(), 0);

    drive_bits(to_bits(32'hFFFFFFFF, 32, 1'b1), 5, 1'b1);
    reset = 1'b1;
    bus.so_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_outputs("midburst_reset");
    reset = 1'b0;
    m_addr = 0;
    m_full = 1'b0;
    idle(1);
    send_burst(to_bits(32'h3C, 8, 1'b1), 8, 1'b1, 4);
    check("queues_drained_final", wq.size() + bq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
